frankie_io_tx: RTL and testbench

- Downstream consumer of the Frankie CPU's 16-bit `io_out` port.
- Watches `io_out` every clock and queues each new value in a small FIFO.
- Serialises each queued word onto a single-wire UART-style line, low byte first, 8N1 per byte.
- Purpose: lets a bench or board observe program output without probing CPU internals.

---
 rtl/frankie_io_pkg.sv | 17 +
 rtl/frankie_io_fifo.sv | 60 ++++++
 rtl/frankie_io_tx.sv | 153 +++++++++++++++
 tb/tb_frankie_io_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frankie_io_pkg.sv
// Shared constants and the serialiser FSM state encoding for the Frankie I/O transmitter.
// The PARITY state is always enumerated; it is only reachable when FRANKIE_IO_TX_PARITY_EN is defined.
package frankie_io_pkg;

    localparam int DATA_W    = 16;
    localparam int BYTE_W    = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/frankie_io_fifo.sv
// Word queue between the io_out change detector and the serialiser.
// Head word is presented combinationally on dout; a push while full is accepted only with a same-edge pop.
module frankie_io_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/frankie_io_tx.sv
// Captures every change on the CPU io_out port into a FIFO and sends each word as two UART bytes, low byte first.
// Optional even parity bit per byte when FRANKIE_IO_TX_PARITY_EN is defined (8E1 instead of 8N1).
module frankie_io_tx
    import frankie_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] io_out,
    output logic              tx,
    output logic              busy,
    output logic              fifo_full,
    output logic              overflow
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(BYTE_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_W - 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nx;
    logic               sel;
    logic               sel_nx;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  shreg_nx;
    logic [DATA_W-1:0]  prev;
    logic [BYTE_W-1:0]  cur_byte;
    logic [DATA_W-1:0]  fifo_dout;
    logic               fifo_empty;
    logic               push_req;
    logic               pop;
    logic               tick;

    assign push_req = (io_out != prev);
    assign cur_byte = sel ? shreg[DATA_W-1:BYTE_W] : shreg[BYTE_W-1:0];
    assign tick     = (cnt == LAST_CNT);
    assign busy     = (state != IDLE) || !fifo_empty;

    frankie_io_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (io_out),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // prev follows io_out unconditionally, so a dropped word is never retried.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            sel      <= 1'b0;
            prev     <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            idx      <= idx_nx;
            sel      <= sel_nx;
            prev     <= io_out;
            overflow <= overflow || (push_req && fifo_full && !pop);
        end
    end

    always_ff @(posedge clock) begin
        shreg <= shreg_nx;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = tick ? '0 : cnt + CNT_W'(1);
        idx_nx   = idx;
        sel_nx   = sel;
        shreg_nx = shreg;
        pop      = 1'b0;
        tx       = 1'b1;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shreg_nx = fifo_dout;
                    sel_nx   = 1'b0;
                    state_nx = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (tick) begin
                    idx_nx   = '0;
                    state_nx = DATA;
                end
            end
            DATA: begin
                tx = cur_byte[idx];
                if (tick) begin
                    if (idx == LAST_IDX) begin
`ifdef FRANKIE_IO_TX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
            end
`ifdef FRANKIE_IO_TX_PARITY_EN
            PARITY: begin
                tx = ^cur_byte;
                if (tick) begin
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                tx = 1'b1;
                if (tick) begin
                    // Queued words follow straight from the stop bit with no idle gap.
                    if (!sel) begin
                        sel_nx   = 1'b1;
                        state_nx = START;
                    end else if (!fifo_empty) begin
                        pop      = 1'b1;
                        shreg_nx = fifo_dout;
                        sel_nx   = 1'b0;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frankie_io_tx.sv
// Directed bench for frankie_io_tx: table of single-word frames plus hand-written multi-cycle sequences.
module tb_frankie_io_tx;

    localparam int CPB = 4;
`ifdef FRANKIE_IO_TX_PARITY_EN
    localparam int BPB = 11;
`else
    localparam int BPB = 10;
`endif
    localparam int WORD_CYC = 2 * BPB * CPB;

    logic        clock  = 1'b0;
    logic        reset  = 1'b0;
    logic [15:0] io_out = 16'h0000;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int start_cyc = 0;

    typedef struct {
        logic [15:0] val;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;

    frankie_io_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_out    (io_out),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_start(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (tx === 1'b0) begin
                ok = 1'b1;
                start_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // pre >= 0: the start bit was already seen that many negedges ago.
    task automatic recv_byte(input string tag, input int pre, output logic [7:0] b);
        bit ok;
        int pos;
        int t;
        b = 8'hxx;
        if (pre < 0) begin
            wait_start(400, ok);
            check({tag, "_start"}, {31'd0, ok}, 32'd1);
            if (!ok) return;
            pos = 0;
        end else begin
            pos = pre;
        end
        for (int i = 0; i < 8; i++) begin
            t = CPB * (1 + i) + CPB / 2;
            repeat (t - pos) @(negedge clock);
            pos = t;
            b[i] = tx;
        end
`ifdef FRANKIE_IO_TX_PARITY_EN
        t = CPB * 9 + CPB / 2;
        repeat (t - pos) @(negedge clock);
        pos = t;
        check({tag, "_parity"}, {31'd0, tx}, {31'd0, ^b});
`endif
        t = CPB * (BPB - 1) + CPB / 2;
        repeat (t - pos) @(negedge clock);
        check({tag, "_stop"}, {31'd0, tx}, 32'd1);
    endtask

    task automatic recv_word(input string tag, input int pre, output logic [15:0] w);
        logic [7:0] lo;
        logic [7:0] hi;
        recv_byte({tag, "_lo"}, pre, lo);
        recv_byte({tag, "_hi"}, -1, hi);
        w = {hi, lo};
    endtask

    initial begin
        vec_t        vecs[6];
        logic [15:0] burst[6];
        logic [15:0] w;
        bit          ok;
        bit          saw;
        int          n;
        int          s0;
        int          offs;

        vecs[0] = '{16'hA55A, 8'h5A, 8'hA5};
        vecs[1] = '{16'h0010, 8'h10, 8'h00};
        vecs[2] = '{16'h00FF, 8'hFF, 8'h00};
        vecs[3] = '{16'h8001, 8'h01, 8'h80};
        vecs[4] = '{16'h0307, 8'h07, 8'h03};
        vecs[5] = '{16'hFFFF, 8'hFF, 8'hFF};
        burst   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};

        // Reset held with io_out at zero.
        #100;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        saw = 1'b0;
        repeat (1000) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) saw = 1'b1;
        end
        check("quiet_after_reset", {31'd0, saw}, 32'd0);

        // Latency to start bit and length of one word frame.
        @(negedge clock);
        io_out = 16'h0010;
        n = 0;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n++;
            if (tx === 1'b0) begin
                saw = 1'b1;
                break;
            end
        end
        check("start_latency", n, 2);
        n = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            n++;
            if (busy === 1'b0) break;
        end
        check("busy_frame_len", n, WORD_CYC);

        // Table of single-word frames.
        foreach (vecs[k]) begin
            @(negedge clock);
            io_out = vecs[k].val;
            recv_word("vec", -1, w);
            check($sformatf("vec%0d_lo", k), {24'd0, w[7:0]}, {24'd0, vecs[k].lo});
            check($sformatf("vec%0d_hi", k), {24'd0, w[15:8]}, {24'd0, vecs[k].hi});
            wait_idle(300, ok);
            check($sformatf("vec%0d_idle", k), {31'd0, ok}, 32'd1);
        end

        // Three changes on consecutive cycles, sent back to back.
        @(negedge clock);
        io_out = 16'h0001;
        @(negedge clock);
        io_out = 16'h0002;
        @(negedge clock);
        io_out = 16'h0003;
        s0 = 0;
        for (int k = 0; k < 3; k++) begin
            recv_word("seq", -1, w);
            if (k == 0) s0 = start_cyc - 2 * BPB * CPB + BPB * CPB;
            if (k == 2) check("seq_no_gap", start_cyc - s0, 2 * WORD_CYC + BPB * CPB);
            check($sformatf("seq%0d_word", k), {16'd0, w}, k + 1);
        end
        wait_idle(300, ok);
        check("seq_total", cyc - s0, 3 * WORD_CYC);

        // Six changes in a row against a four-deep queue: sixth is dropped.
        check("ovf_before", {31'd0, overflow}, 32'd0);
        offs = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (offs >= 0) offs++;
            else if (tx === 1'b0) offs = 0;
            io_out = burst[k];
        end
        @(negedge clock);
        if (offs >= 0) offs++;
        else if (tx === 1'b0) offs = 0;
        check("ovf_start_offset", offs, 4);
        check("ovf_full", {31'd0, fifo_full}, 32'd1);
        check("ovf_sticky_set", {31'd0, overflow}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            recv_word("ovf", (k == 0 && offs >= 0) ? offs : -1, w);
            check($sformatf("ovf%0d_word", k), {16'd0, w}, {16'd0, burst[k]});
        end
        wait_idle(300, ok);
        check("ovf_idle", {31'd0, ok}, 32'd1);
        wait_start(200, saw);
        check("ovf_no_sixth", {31'd0, saw}, 32'd0);
        check("ovf_still_set", {31'd0, overflow}, 32'd1);

        // Reset during a data bit of the high byte.
        @(negedge clock);
        io_out = 16'hBEEF;
        recv_byte("abort_lo", -1, w[7:0]);
        check("abort_lo_val", {24'd0, w[7:0]}, 32'hEF);
        wait_start(100, ok);
        check("abort_hi_start", {31'd0, ok}, 32'd1);
        repeat (CPB + CPB / 2) @(negedge clock);
        check("abort_pre_tx", {31'd0, tx}, 32'd0);
        #2;
        reset  = 1'b0;
        io_out = 16'h0000;
        #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_overflow", {31'd0, overflow}, 32'd0);
        check("abort_full", {31'd0, fifo_full}, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        saw = 1'b0;
        repeat (200) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) saw = 1'b1;
        end
        check("abort_no_residual", {31'd0, saw}, 32'd0);
        check("abort_overflow_after", {31'd0, overflow}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
